// File: rtl/mul8_pkg.sv
// Shared definitions for the 8x8 shift-and-add multiplier datapath.
package mul8_pkg;

  localparam int unsigned MUL_N = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFlush,
    StDone
  } mul_state_e;

endpackage

// File: rtl/mul8_ctrl.sv
// Sequencer for the shift-and-add multiplier: FSM, step counter, done/busy flags,
// and load/step strobes for the datapath held in the parent.
module mul8_ctrl
  import mul8_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic load_o,
  output logic step_o,
  output logic done_o,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(N) + 1;

  mul_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    load_o  = 1'b0;
    step_o  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StCalc;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          load_o  = 1'b1;
        end
      end
      StCalc: begin
        step_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // Last of the N steps; counter ends at N and never wraps.
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StDone;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/shift_add_mul8.sv
// Sequential shift-and-add unsigned multiplier; one partial-product add per clock.
// product is the accumulator itself, so partial sums are visible while done is low.
module shift_add_mul8
  import mul8_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy
);

  logic           load, step;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [2*N-1:0] acc_q, acc_d;

  mul8_ctrl #(
    .N(N)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .load_o (load),
    .step_o (step),
    .done_o (done),
    .busy_o (busy)
  );

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (load) begin
      mcand_d = {{N{1'b0}}, a};
      mplr_d  = b;
      acc_d   = '0;
    end else if (step) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

  assign product = acc_q;

endmodule

// File: doc/shift_add_mul8.md
# shift_add_mul8

Sequential shift-and-add unsigned multiplier core for the 8x8 multiplier datapath. It sits directly upstream of the product capture register. It accepts two N-bit operands on a `start` pulse and computes one partial-product accumulation per clock. It drives the running accumulator on `product` with `done` low while working, then raises `done` so the capture stage freezes its answer.

## Interface

Parameters:
- `N`, default 8: operand width; `product` is 2N bits.

Ports:
- `clk`: input, 1 bit. Clock, rising edge.
- `rst`: input, 1 bit. Reset, asynchronous, active-low.
- `start`: input, 1 bit. Begin a multiplication; sampled only in IDLE or DONE.
- `a`: input, N bits. Multiplicand; sampled on the start edge only.
- `b`: input, N bits. Multiplier; sampled on the start edge only.
- `product`: output, 2N bits. Accumulator register; partial sums during CALC, final result from FLUSH onward.
- `done`: output, 1 bit. Registered. Low while an operation is in flight; high when idle or finished.
- `busy`: output, 1 bit. Registered. High in CALC and FLUSH.

## Operation

- States: IDLE, CALC, FLUSH, DONE.
- Reset values: state IDLE, `product` 0, `done` 1, `busy` 0, counter 0, internal shift registers 0.
- Entering CALC from IDLE or DONE with `start`=1:
  - mcand (2N bits) <= zero-extended `a`
  - mplr (N bits) <= `b`
  - acc <= 0, cnt <= 0
  - `done` <= 0, `busy` <= 1
- Each CALC edge:
  - if mplr[0]: acc <= acc + mcand (2N-bit add, no overflow possible)
  - mcand <<= 1; mplr >>= 1; cnt <= cnt + 1
- CALC to FLUSH on the edge where cnt == N-1, so exactly N add/shift steps run. The counter is $clog2(N)+1 bits and does not wrap.
- FLUSH lasts one cycle. `product` holds the final value and `done` is still 0, so the downstream register captures the final result on the FLUSH edge.
- FLUSH to DONE: `done` <= 1, `busy` <= 0.
- DONE holds `product` until the next `start`.
  - `start`=1 in DONE restarts immediately, same as from IDLE.
  - There is no return to IDLE except through reset.
- `start` in CALC or FLUSH is ignored. `a` and `b` changes after the start edge are ignored.
- `product` is the acc register itself; there is no separate output register.

## Timing

- Edge E0 samples `start`. After E0, `done`=0, `busy`=1, `product`=0.
- Edges E1..EN perform the N steps. After EN, state is FLUSH and `product` is final.
- Edge EN+1 moves to DONE and raises `done`. For N=8 that is edge E9.
- Start to `done` high takes N+1 edges after E0. Minimum start-to-start spacing is N+2 edges.
- `done` is low for exactly N+1 capture edges (E1..EN+1). The final value is presented on edge EN+1.
- Reset asserted mid-operation:
  - Immediate asynchronous return to IDLE; `product` 0, `done` 1, `busy` 0.
  - No partial result survives.
  - After `rst` deasserts, the first rising edge with `start`=1 behaves as E0.
- `start` held high continuously gives back-to-back operations, each re-sampling `a` and `b` on its DONE-state edge.

## Structure

- Shared package `mul8_pkg` holds:
  - the state enum (IDLE, CALC, FLUSH, DONE) as a 2-bit encoding
  - the default width constant `MUL_N` = 8, also used by the capture register and top level
- Natural split into one sub-module, `mul8_ctrl`:
  - contains the FSM, step counter, `done` and `busy`
  - outputs `load` and `step` strobes to the datapath (mcand, mplr, acc) kept in the parent
- The datapath has no further sub-modules.

## Test plan

- `a`=0x0F, `b`=0x0F, single start pulse -> `product`=0x00E1 at FLUSH; `done` rises exactly 9 edges after the start edge; `busy` low in DONE.
- `a`=0xFF, `b`=0xFF -> 0xFE01. `a`=0x00, `b`=0xA5 -> 0x0000. `a`=0x80, `b`=0x02 -> 0x0100.
- Start pulse at E3 of an operation with different operands -> ignored; result of the first operation is unchanged and timing is unchanged.
- `rst` low at E4 of an 0xFF*0xFF operation -> `product` 0, `done` 1, `busy` 0 immediately. A new 0x12*0x34 started after release -> 0x03A8.
- `start` held high with operands changing each operation: 3*5, then 7*9 -> 0x000F, then 0x003F. The second E0 is the DONE-state edge, and `done` drops for N+1 edges.
- Capture-register model (loads `product` while `done`=0, holds while `done`=1) connected -> captured answer equals a*b for 200 random operand pairs.
